// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and constants for the edge event arbiter: the event record
// and the two-state presentation FSM encoding.
package edge_arb_pkg;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int MAX_CH_W       = 4;  // wide enough for the 16-channel maximum

    typedef struct packed {
        logic [MAX_CH_W-1:0] chan;
        logic                is_rise;
    } evt_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event stream between the arbiter (master) and the shared
// interrupt/log consumer (slave).
interface edge_event_arbiter_if #(
    parameter int NUM_CH = edge_arb_pkg::DEFAULT_NUM_CH
) ();
    localparam int CH_W = $clog2(NUM_CH);

    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [CH_W-1:0] evt_chan_o;
    logic            evt_is_rise_o;

    modport master (
        output evt_valid_o,
        output evt_chan_o,
        output evt_is_rise_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_chan_o,
        input  evt_is_rise_o,
        output evt_ready_i
    );
endinterface

// File: rtl/edge_event_arbiter_rr.sv
// Combinational round-robin arbiter: rotate the request vector so ptr lands
// on bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int         W     = $clog2(N);
    localparam logic [W:0] N_EXT = (W+1)'(N);

    logic [N-1:0] w_rot;
    logic [W:0]   w_idx;
    logic [W-1:0] w_off;
    logic [W:0]   w_sum;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path can leave it holding its old value and infer a latch.
    always_comb begin
        w_rot = '0;
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, ptr} + (W+1)'(i);
            if (w_idx >= N_EXT) w_idx = w_idx - N_EXT;
            w_rot[i] = req[w_idx[W-1:0]];
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = W'(i);
        end
    end

    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= N_EXT) w_sum = w_sum - N_EXT;
    end

    assign gnt_valid = |w_rot;
    assign gnt_idx   = w_sum[W-1:0];

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches per-channel rise/fall edge pulses as pending events and serialises
// them round-robin onto one valid/ready stream, flagging merged (lost) pulses.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   rise_i,
    input  logic [NUM_CH-1:0]   fall_i,
    input  logic [NUM_CH-1:0]   mask_i,
    input  logic [NUM_CH-1:0]   clr_overflow_i,
    output logic [NUM_CH-1:0]   overflow_o,
    edge_event_arbiter_if.master evt_if
);
    localparam int CH_W = $clog2(NUM_CH);

    state_t            r_state, w_state_nxt;
    evt_t              r_evt, w_evt_nxt;
    logic [NUM_CH-1:0] r_rise_pend, r_fall_pend, r_ovf;
    logic [CH_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;

    logic [NUM_CH-1:0] w_rise_set, w_fall_set, w_req, w_gnt_oh;
    logic [NUM_CH-1:0] w_rise_clr, w_fall_clr, w_ovf_set;
    logic [CH_W-1:0]   w_after_ptr, w_search_ptr, w_gnt_idx;
    logic              w_gnt_valid, w_hs, w_load, w_sel_rise;

    assign w_rise_set = rise_i & mask_i;
    assign w_fall_set = fall_i & mask_i;
    assign w_req      = r_rise_pend | r_fall_pend;
    assign w_hs       = (r_state == ST_PRESENT) && evt_if.evt_ready_i;

    // On a handshake the next search already starts after the presented
    // channel, so back-to-back loads stay fair without waiting for rr_ptr.
    assign w_after_ptr  = (r_evt.chan == MAX_CH_W'(NUM_CH - 1)) ? '0
                                                                : CH_W'(r_evt.chan + 1'b1);
    assign w_search_ptr = w_hs ? w_after_ptr : r_rr_ptr;

    rr_arbiter #(.N(NUM_CH)) u_rr_arbiter (
        .req       (w_req),
        .ptr       (w_search_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_sel_rise = r_rise_pend[w_gnt_idx];
    assign w_gnt_oh   = NUM_CH'(1) << w_gnt_idx;

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (w_hs) begin
                    w_rr_ptr_nxt = w_after_ptr;
                    if (w_gnt_valid) w_load      = 1'b1;
                    else             w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_evt_nxt = r_evt;
        if (w_load) begin
            w_evt_nxt.chan    = MAX_CH_W'(w_gnt_idx);
            w_evt_nxt.is_rise = w_sel_rise;
        end
    end

    assign w_rise_clr = (w_load &&  w_sel_rise) ? w_gnt_oh : '0;
    assign w_fall_clr = (w_load && !w_sel_rise) ? w_gnt_oh : '0;

    // A pulse on a bit that is leaving for the output re-arms it instead of overflowing.
    assign w_ovf_set = (w_rise_set & r_rise_pend & ~w_rise_clr)
                     | (w_fall_set & r_fall_pend & ~w_fall_clr);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_evt       <= '0;
            r_rr_ptr    <= '0;
            r_rise_pend <= '0;
            r_fall_pend <= '0;
            r_ovf       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_evt       <= w_evt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_rise_pend <= (r_rise_pend & ~w_rise_clr) | w_rise_set;
            r_fall_pend <= (r_fall_pend & ~w_fall_clr) | w_fall_set;
            r_ovf       <= (r_ovf & ~clr_overflow_i) | w_ovf_set;
        end
    end

    assign evt_if.evt_valid_o   = (r_state == ST_PRESENT);
    assign evt_if.evt_chan_o    = CH_W'(r_evt.chan);
    assign evt_if.evt_is_rise_o = r_evt.is_rise;
    assign overflow_o           = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed vector table plus a scoreboarded random soak for edge_event_arbiter
// with four channels.
module tb_edge_event_arbiter;

    localparam logic [3:0] F = 4'hF;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rise_i, fall_i, mask_i, clr_overflow_i, overflow_o;

    edge_event_arbiter_if #(.NUM_CH(4)) evt_if ();

    edge_event_arbiter #(.NUM_CH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .rise_i         (rise_i),
        .fall_i         (fall_i),
        .mask_i         (mask_i),
        .clr_overflow_i (clr_overflow_i),
        .overflow_o     (overflow_o),
        .evt_if         (evt_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] rise, fall, mask;
        logic       ready;
        logic [3:0] clr;
        logic       exp_valid;
        logic [1:0] exp_chan;
        logic       exp_rise;
        logic [3:0] exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Scoreboard model state
    logic [3:0] m_rise, m_fall, m_ovf;
    logic       m_valid, m_isr;
    int         m_chan, m_ptr;
    int         pulses, merged, delivered;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] rise, input logic [3:0] fall,
                       input logic [3:0] mask, input logic ready, input logic [3:0] clr,
                       input logic ev, input logic [1:0] ech, input logic er,
                       input logic [3:0] eovf);
        vec_t v;
        v.rst = rst; v.rise = rise; v.fall = fall; v.mask = mask; v.ready = ready;
        v.clr = clr; v.exp_valid = ev; v.exp_chan = ech; v.exp_rise = er; v.exp_ovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] r, input logic [3:0] f,
                         input logic [3:0] m, input logic rdy, input logic [3:0] c);
        reset = rst; rise_i = r; fall_i = f; mask_i = m;
        evt_if.evt_ready_i = rdy; clr_overflow_i = c;
    endtask

    task automatic model_reset();
        m_rise = '0; m_fall = '0; m_ovf = '0; m_valid = 1'b0; m_isr = 1'b0;
        m_chan = 0; m_ptr = 0;
    endtask

    // Behavioural next-state of the arbiter for one clock edge.
    task automatic model_step(input logic [3:0] r, input logic [3:0] f, input logic [3:0] m,
                              input logic rdy, input logic [3:0] clr);
        logic       hs, found;
        logic [3:0] new_ovf;
        int         s, g;
        hs = m_valid && rdy;
        s  = hs ? (m_chan + 1) % 4 : m_ptr;
        if (hs) m_ptr = (m_chan + 1) % 4;
        if (!m_valid || hs) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                g = (s + k) % 4;
                if (!found && (m_rise[g] || m_fall[g])) begin
                    found  = 1'b1;
                    m_chan = g;
                    m_isr  = m_rise[g];
                    if (m_rise[g]) m_rise[g] = 1'b0;
                    else           m_fall[g] = 1'b0;
                end
            end
            m_valid = found;
        end
        new_ovf = '0;
        for (int c = 0; c < 4; c++) begin
            if (r[c] && m[c]) begin
                pulses++;
                if (m_rise[c]) begin merged++; new_ovf[c] = 1'b1; end
                m_rise[c] = 1'b1;
            end
            if (f[c] && m[c]) begin
                pulses++;
                if (m_fall[c]) begin merged++; new_ovf[c] = 1'b1; end
                m_fall[c] = 1'b1;
            end
        end
        m_ovf = (m_ovf & ~clr) | new_ovf;
    endtask

    initial begin
        logic [3:0] r, f, m, c;
        logic       rdy, dut_hs;

        // Basic latency
        add(0, 4'b0100, 0, F, 1, 0,   0, 0, 0, 0);
        add(0, 0,       0, F, 1, 0,   1, 2, 1, 0);
        add(0, 0,       0, F, 1, 0,   0, 0, 0, 0);
        // Round-robin from a fresh pointer, then ch0+ch3
        add(1, 0,       0, F, 1, 0,   0, 0, 0, 0);
        add(0, 4'hF,    0, F, 1, 0,   0, 0, 0, 0);
        add(0, 0,       0, F, 1, 0,   1, 0, 1, 0);
        add(0, 0,       0, F, 1, 0,   1, 1, 1, 0);
        add(0, 0,       0, F, 1, 0,   1, 2, 1, 0);
        add(0, 0,       0, F, 1, 0,   1, 3, 1, 0);
        add(0, 0,       0, F, 1, 0,   0, 0, 0, 0);
        add(0, 4'b1001, 0, F, 1, 0,   0, 0, 0, 0);
        add(0, 0,       0, F, 1, 0,   1, 0, 1, 0);
        add(0, 0,       0, F, 1, 0,   1, 3, 1, 0);
        add(0, 0,       0, F, 1, 0,   0, 0, 0, 0);
        // Rise and fall on ch3 together
        add(0, 4'b1000, 4'b1000, F, 1, 0,   0, 0, 0, 0);
        add(0, 0,       0,       F, 1, 0,   1, 3, 1, 0);
        add(0, 0,       0,       F, 1, 0,   1, 3, 0, 0);
        add(0, 0,       0,       F, 1, 0,   0, 0, 0, 0);
        // Masking
        add(0, 4'b0011, 0, 4'b1110, 1, 0,   0, 0, 0, 0);
        add(0, 0,       0, F,       1, 0,   1, 1, 1, 0);
        add(0, 0,       0, F,       1, 0,   0, 0, 0, 0);
        add(0, 0,       0, F,       1, 0,   0, 0, 0, 0);
        // Back-pressure and overflow on ch1 fall
        add(0, 0, 4'b0010, F, 0, 0,         0, 0, 0, 0);
        add(0, 0, 0,       F, 0, 0,         1, 1, 0, 0);
        add(0, 0, 4'b0010, F, 0, 0,         1, 1, 0, 0);
        add(0, 0, 0,       F, 0, 0,         1, 1, 0, 0);
        add(0, 0, 4'b0010, F, 0, 0,         1, 1, 0, 4'b0010);
        add(0, 0, 4'b0010, F, 0, 4'b0010,   1, 1, 0, 4'b0010);
        for (int i = 0; i < 4; i++) add(0, 0, 0, F, 0, 0, 1, 1, 0, 4'b0010);
        add(0, 0, 0, F, 1, 0,               1, 1, 0, 4'b0010);
        add(0, 0, 0, F, 1, 0,               0, 0, 0, 4'b0010);
        add(0, 0, 0, F, 1, 4'b0010,         0, 0, 0, 0);
        add(0, 0, 0, F, 1, 0,               0, 0, 0, 0);
        // Pulse on the bit being moved to the output re-arms it
        add(0, 0, 4'b0010, F, 0, 0,         0, 0, 0, 0);
        add(0, 0, 4'b0010, F, 0, 0,         1, 1, 0, 0);
        add(0, 0, 0,       F, 1, 0,         1, 1, 0, 0);
        add(0, 0, 0,       F, 1, 0,         0, 0, 0, 0);
        // Reset while an event is presented
        add(0, 4'hF, 0, F, 0, 0,            0, 0, 0, 0);
        add(0, 0,    0, F, 0, 0,            1, 2, 1, 0);
        add(1, 0,    0, F, 1, 0,            0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, F, 1, 0, 0, 0, 0, 0);

        drive(1, 0, 0, F, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid",   32'(evt_if.evt_valid_o),   0);
        check("reset_chan",    32'(evt_if.evt_chan_o),    0);
        check("reset_is_rise", 32'(evt_if.evt_is_rise_o), 0);
        check("reset_ovf",     32'(overflow_o),           0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rise, vecs[i].fall, vecs[i].mask, vecs[i].ready, vecs[i].clr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(evt_if.evt_valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ovf", i),   32'(overflow_o),         32'(vecs[i].exp_ovf));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_chan", i),    32'(evt_if.evt_chan_o),    32'(vecs[i].exp_chan));
                check($sformatf("vec%0d_is_rise", i), 32'(evt_if.evt_is_rise_o), 32'(vecs[i].exp_rise));
            end
        end

        // Random soak against the behavioural model, then a drain
        drive(1, 0, 0, F, 0, 0);
        @(posedge clk);
        #1;
        model_reset();
        pulses = 0; merged = 0; delivered = 0;
        for (int cyc = 0; cyc < 230; cyc++) begin
            if (cyc < 200) begin
                r   = 4'($urandom) & 4'($urandom);
                f   = 4'($urandom) & 4'($urandom);
                m   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : F;
                rdy = ($urandom_range(0, 9) < 7);
                c   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            end else begin
                r = 0; f = 0; m = F; rdy = 1'b1; c = 0;
            end
            drive(0, r, f, m, rdy, c);
            dut_hs = evt_if.evt_valid_o && rdy;
            model_step(r, f, m, rdy, c);
            @(posedge clk);
            #1;
            if (dut_hs) delivered++;
            check($sformatf("soak%0d_valid", cyc), 32'(evt_if.evt_valid_o), 32'(m_valid));
            check($sformatf("soak%0d_ovf", cyc),   32'(overflow_o),         32'(m_ovf));
            if (m_valid) begin
                check($sformatf("soak%0d_chan", cyc),    32'(evt_if.evt_chan_o),    32'(m_chan));
                check($sformatf("soak%0d_is_rise", cyc), 32'(evt_if.evt_is_rise_o), 32'(m_isr));
            end
        end
        check("soak_event_count", 32'(delivered), 32'(pulses - merged));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Collects single-cycle rising/falling edge pulses from NUM_CH edge detectors and latches each as a pending event.
- Serialises pending events onto one valid/ready event stream for a single shared consumer (interrupt or log unit).
- Channels are served round-robin; a channel's rise is served before its fall.
- Sits directly downstream of the per-signal edge detector bank.

Parameters:
- NUM_CH, 4, number of detector channels (2..16).
- CH_W, $clog2(NUM_CH), width of the channel index. Derived, not overridable.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- rise_i  input  NUM_CH  rising-edge pulses, one bit per channel, one cycle wide.
- fall_i  input  NUM_CH  falling-edge pulses, one bit per channel.
- mask_i  input  NUM_CH  1 = channel enabled; 0 = its pulses are ignored.
- evt_valid_o  output  1  event on the output is valid.
- evt_ready_i  input  1  consumer accepts the event.
- evt_chan_o  output  CH_W  channel index of the presented event.
- evt_is_rise_o  output  1  1 = rising event, 0 = falling event.
- overflow_o  output  NUM_CH  sticky per-channel lost-event flag.
- clr_overflow_i  input  NUM_CH  clears the matching overflow bits.

Behaviour:
- Reset: all of the following are 0 at the first edge with reset = 1, and reset overrides every other input.
  - rise_pend and fall_pend.
  - evt_valid_o, evt_chan_o, evt_is_rise_o.
  - overflow_o.
  - Round-robin pointer rr_ptr.
- Reset mid-transfer drops the presented event and all pending events. No handshake completes in that cycle.
- Pending capture: a rise_i[c] & mask_i[c] pulse sampled at edge t sets rise_pend[c] at edge t. fall_i works the same way.
- Masking: changing mask_i does not clear bits that are already pending.
- Requests: req[c] = rise_pend[c] | fall_pend[c].
- Arbitration: round-robin. Search starts at rr_ptr, wraps at NUM_CH-1 back to 0, and grants the first c with req[c] = 1.
- Within the granted channel, rise is selected if rise_pend is set; otherwise fall.
- FSM has two states:
  - IDLE (valid = 0).
  - PRESENT (valid = 1).
- IDLE -> PRESENT: if any req, load {chan, is_rise} into the output register and clear the selected pending bit. Both happen at the same edge.
- PRESENT, hold: while evt_ready_i = 0, evt_valid_o, evt_chan_o and evt_is_rise_o stay stable.
- PRESENT, handshake (valid & ready):
  - rr_ptr <= presented chan + 1, with wrap.
  - If any req exists, load the next event at the same edge and stay in PRESENT. Throughput is 1 event/cycle.
  - Otherwise go to IDLE.
- Fairness: rr_ptr advances only on a handshake. A channel with both rise and fall pending therefore gets its fall served right after its rise only if no other channel lies between them in round-robin order.
- Latency: pulse at edge t -> evt_valid_o = 1 after edge t+1, when idle and uncontended.
- Same-edge set vs clear: a new pulse on a bit whose pending flag is being cleared (moved to output) sets the bit again. Set wins; nothing is lost.
- Overflow:
  - A masked-in pulse on a pending bit that is already set and not being cleared that edge sets overflow_o[c]. The event is merged, so only one is delivered.
  - overflow_o[c] is sticky until clr_overflow_i[c].
  - A set and a clear on the same edge: set wins.
- Simultaneous rise_i[c] and fall_i[c] set both pending bits. The rise is delivered first.

Decomposition:
- Package edge_arb_pkg:
  - evt_t struct {chan, is_rise}.
  - DEFAULT_NUM_CH = 4.
  - FSM state enum {ST_IDLE, ST_PRESENT}.
- Sub-module rr_arbiter (parameter N). Inputs: req[N], ptr. Outputs: gnt_valid, gnt_idx. Purely combinational, using a rotate-and-priority-encode scheme.
- Pending, overflow and FSM logic stay in the top module.

Test Plan (NUM_CH = 4, mask_i = 4'hF unless stated):
- Basic latency: after reset, rise_i = 4'b0100 for 1 cycle, ready = 1 -> valid high exactly 2 edges after the pulse with chan = 2, is_rise = 1, for one cycle only; overflow = 0.
- Round-robin: rise_i = 4'b1111 in one cycle, ready = 1 -> chan sequence 0,1,2,3 on consecutive cycles. Then a pulse on ch 0 and ch 3 -> order 0,3.
- Back-pressure/overflow: fall_i[1] pulse, ready = 0 for 10 cycles, two more fall_i[1] pulses meanwhile.
  - Event (1, fall) is held stable.
  - The second pulse sets pending with no overflow; the third sets overflow_o[1] = 1.
  - After ready = 1, exactly 2 events for ch 1 are delivered.
  - clr_overflow_i[1] clears the flag.
- Rise/fall same cycle: rise_i[3] = fall_i[3] = 1 -> events (3, rise) then (3, fall).
- Masking: mask_i = 4'b1110, rise_i = 4'b0011 -> only (1, rise) delivered.
- Reset mid-operation: rise_i = 4'hF, ready = 0, assert reset for 1 cycle -> valid = 0 and no event appears afterwards.
- Randomised soak: 200 cycles of random pulses and ready, with a scoreboard model. Check event count = pulses - merged pulses, and check ordering.
